user_gpio_irq: RTL and testbench
================================

# user_gpio_irq

Parametrised APB4 GPIO controller for the user IP slot. It extends the basic pad-control register set (OE/CS/PU/PD/DO/DI) with a configurable pin count, a two-flop input synchroniser and a per-pin glitch filter. It also adds atomic set/clear/toggle of output data and per-pin edge/level interrupts with W1C status and a single `irq_o` line. It drives the pads through `nmi_gpio_if` and is programmed over `apb4_if`.

## Interface
- `ID`, 8'd255, value returned by the ID register.
- `GPIO_NUM`, 16, number of pins, legal range 1..32. Register bits [31:GPIO_NUM] read 0 and ignore writes.
- `clk_i`  in  1  single clock; all logic in this domain.
- `rst_i`  in  1  reset, asynchronous, active-high; clears every flop.
- `gpio`  nmi_gpio_if.dut  —  pad bundle: `gpio_in` (input) and `gpio_oe`/`gpio_cs`/`gpio_pu`/`gpio_pd`/`gpio_out` (outputs). Only [GPIO_NUM-1:0] are used.
- `apb`  apb4_if.slave  —  register port. Decode uses `paddr[7:0]`.
- `irq_o`  out  1  level interrupt: OR of `IRQ_STAT & IRQ_EN`.

## Operation
- Address map (rw unless noted):
  - 0x00 ID (ro, `{24'd0,ID}`)
  - 0x04 OE, 0x08 CS, 0x0C PU, 0x10 PD, 0x14 DO
  - 0x18 DI (ro, filtered input)
  - 0x1C DO_SET (wo), 0x20 DO_CLR (wo), 0x24 DO_TGL (wo)
  - 0x28 IRQ_EN
  - 0x2C IRQ_TYPE (1 = edge, 0 = level)
  - 0x30 IRQ_POL (1 = rising/high, 0 = falling/low)
  - 0x34 IRQ_BOTH (1 = both edges; overrides POL, edge mode only)
  - 0x38 IRQ_STAT (rw1c)
  - 0x3C FLT_EN
  - 0x40 FLT_CNT (4 bits, [3:0])
- Write-only registers read 0. Unmapped reads return 0; unmapped writes are ignored.
- Pad outputs: `gpio_oe`=OE, `gpio_cs`=CS, `gpio_pu`=PU, `gpio_pd`=PD, `gpio_out`=DO.
- DO update rules:
  - DO_SET: `DO |= wdata`.
  - DO_CLR: `DO &= ~wdata`.
  - DO_TGL: `DO ^= wdata`.
  - Direct write to DO replaces the value.
- Input path: `gpio_in` → sync1 → sync2 → filter → `flt`. `prev` holds `flt` delayed by one cycle.
- Filter, per pin:
  - FLT_EN=0: `flt` = sync2 (combinational).
  - FLT_EN=1: a 4-bit counter increments while sync2 ≠ `flt` and resets to 0 when they match. When the counter reaches FLT_CNT, `flt` takes sync2 on that edge and the counter clears. A change is therefore accepted after FLT_CNT+1 consecutive mismatching cycles.
  - Changing FLT_EN or FLT_CNT clears all filter counters.
- Event per pin, evaluated only where IRQ_EN=1:
  - Rise = `flt & ~prev`; fall = `~flt & prev`.
  - Edge mode: BOTH ? (rise | fall) : (POL ? rise : fall).
  - Level mode: POL ? `flt` : `~flt`.
- IRQ_STAT bit update each cycle: `next = (stat & ~w1c_mask) | event`. The set wins over a simultaneous W1C.
  - In level mode the bit re-sets every cycle while the level persists.
- Clearing an IRQ_EN bit does not clear its STAT bit; it only masks `irq_o`.

## Timing
- APB: `pready` is tied to 1 (zero wait states); `pslverr` is tied to 0.
  - `prdata` is combinational during the access phase (psel & penable & ~pwrite) and 0 otherwise.
  - Writes commit on the clk edge that ends the access phase. A read in the next access sees the new value.
- Reset values:
  - All registers, sync flops, `prev`, `flt` and counters are 0.
  - All pad outputs are 0; `irq_o` is 0.
  - Reset assertion takes effect immediately, with no clock needed. An assertion mid-APB-transfer discards that write.
- Latency from `gpio_in` settling before edge E0, with FLT_EN=0:
  - sync1 captures at E0; sync2 and DI reflect the pin after E1.
  - An edge event is registered into IRQ_STAT at E2; `irq_o` rises after E2 (combinational from STAT & EN).
- With FLT_EN=1, add FLT_CNT+1 cycles before `flt` changes.
- After reset, `prev`=0, so a pin already high produces a rising event at E2 only if IRQ_EN is set by then. Firmware clears STAT after enabling.
- W1C of a bit with no concurrent event: `irq_o` falls on the commit edge.

## Test plan
- **Reset and ID:** assert `rst_i` mid-transfer → all pad outputs and `irq_o` are 0 immediately. Read 0x00 → 0x000000FF; read 0x44 → 0.
- **Atomic DO:** write DO=0x00F0, then DO_SET 0x000F → 0x00FF. DO_CLR 0x0081 → 0x007E. DO_TGL 0xFFFF → 0xFF81, with `gpio_out` matching after each commit.
- **Rising-edge IRQ:** EN[3]=1, TYPE[3]=1, POL[3]=1, then pin 3 goes 0→1 → STAT=0x0008 and `irq_o`=1 exactly 3 edges after pin change. W1C 0x0008 → `irq_o`=0.
- **Level-low IRQ, W1C vs set:** EN[5]=1, TYPE=0, POL=0, pin 5 held low; W1C 0x0020 → STAT[5] stays 1. Release pin → W1C then clears it.
- **Glitch filter:** FLT_EN[0]=1, FLT_CNT=3. A 3-cycle pulse on pin 0 leaves DI[0]=0 and no event. A 4-cycle pulse sets DI[0]=1 after 2+4 edges.
- **Both edges, GPIO_NUM=32:** BOTH[31]=1, EN[31]=1, pulse pin 31 → two events, each cleared by W1C 0x80000000. Bits above GPIO_NUM=8 read 0 in a second build.

Source files
------------

// File: rtl/user_gpio_irq_if.sv
// Pad bundle and APB4 register-port interfaces used by user_gpio_irq.
// Both are fixed at 32 bits; a narrower controller drives its unused pad bits to 0.
interface nmi_gpio_if;
    logic [31:0] gpio_in;
    logic [31:0] gpio_oe;
    logic [31:0] gpio_cs;
    logic [31:0] gpio_pu;
    logic [31:0] gpio_pd;
    logic [31:0] gpio_out;

    modport dut (
        input  gpio_in,
        output gpio_oe, gpio_cs, gpio_pu, gpio_pd, gpio_out
    );

    modport pad (
        output gpio_in,
        input  gpio_oe, gpio_cs, gpio_pu, gpio_pd, gpio_out
    );
endinterface

interface apb4_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/user_gpio_irq.sv
// APB4 GPIO controller: pad control, atomic DO set/clear/toggle, synchronised and
// glitch-filtered inputs, per-pin edge/level interrupts with W1C status.
module user_gpio_irq #(
    parameter logic [7:0] ID       = 8'd255,
    parameter int         GPIO_NUM = 16
) (
    input  logic    clk_i,
    input  logic    rst_i,
    nmi_gpio_if.dut gpio,
    apb4_if.slave   apb,
    output logic    irq_o
);

    localparam logic [7:0] ADDR_ID       = 8'h00;
    localparam logic [7:0] ADDR_OE       = 8'h04;
    localparam logic [7:0] ADDR_CS       = 8'h08;
    localparam logic [7:0] ADDR_PU       = 8'h0C;
    localparam logic [7:0] ADDR_PD       = 8'h10;
    localparam logic [7:0] ADDR_DO       = 8'h14;
    localparam logic [7:0] ADDR_DI       = 8'h18;
    localparam logic [7:0] ADDR_DO_SET   = 8'h1C;
    localparam logic [7:0] ADDR_DO_CLR   = 8'h20;
    localparam logic [7:0] ADDR_DO_TGL   = 8'h24;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'h28;
    localparam logic [7:0] ADDR_IRQ_TYPE = 8'h2C;
    localparam logic [7:0] ADDR_IRQ_POL  = 8'h30;
    localparam logic [7:0] ADDR_IRQ_BOTH = 8'h34;
    localparam logic [7:0] ADDR_IRQ_STAT = 8'h38;
    localparam logic [7:0] ADDR_FLT_EN   = 8'h3C;
    localparam logic [7:0] ADDR_FLT_CNT  = 8'h40;

    logic [GPIO_NUM-1:0] r_oe, r_cs, r_pu, r_pd, r_do;
    logic [GPIO_NUM-1:0] r_en, r_type, r_pol, r_both, r_stat, r_flt_en;
    logic [3:0]          r_flt_cnt;
    logic [GPIO_NUM-1:0] r_sync1, r_sync2, r_flt, r_prev;
    logic [3:0]          r_cnt [GPIO_NUM];

    logic                w_wr, w_rd, w_cfg_chg;
    logic [7:0]          w_addr;
    logic [GPIO_NUM-1:0] w_wdata, w_pin, w_flt, w_rise, w_fall, w_event, w_w1c;
    logic [31:0]         w_rdata;

    assign w_addr  = apb.paddr[7:0];
    assign w_wdata = apb.pwdata[GPIO_NUM-1:0];
    assign w_pin   = gpio.gpio_in[GPIO_NUM-1:0];
    assign w_wr    = apb.psel & apb.penable & apb.pwrite;
    assign w_rd    = apb.psel & apb.penable & ~apb.pwrite;

    // An unfiltered pin bypasses the filter register so DI sees sync2 directly.
    assign w_flt   = (r_flt_en & r_flt) | (~r_flt_en & r_sync2);
    assign w_rise  = w_flt & ~r_prev;
    assign w_fall  = ~w_flt & r_prev;
    assign w_event = r_en & ((r_type & ((r_both & (w_rise | w_fall)) |
                                        (~r_both & ((r_pol & w_rise) | (~r_pol & w_fall))))) |
                             (~r_type & ((r_pol & w_flt) | (~r_pol & ~w_flt))));
    assign w_w1c   = (w_wr && w_addr == ADDR_IRQ_STAT) ? w_wdata : '0;

    assign w_cfg_chg = w_wr && ((w_addr == ADDR_FLT_EN  && w_wdata != r_flt_en) ||
                                (w_addr == ADDR_FLT_CNT && apb.pwdata[3:0] != r_flt_cnt));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_oe      <= '0;
            r_cs      <= '0;
            r_pu      <= '0;
            r_pd      <= '0;
            r_do      <= '0;
            r_en      <= '0;
            r_type    <= '0;
            r_pol     <= '0;
            r_both    <= '0;
            r_stat    <= '0;
            r_flt_en  <= '0;
            r_flt_cnt <= '0;
        end else begin
            r_stat <= (r_stat & ~w_w1c) | w_event;
            if (w_wr) begin
                case (w_addr)
                    ADDR_OE:       r_oe      <= w_wdata;
                    ADDR_CS:       r_cs      <= w_wdata;
                    ADDR_PU:       r_pu      <= w_wdata;
                    ADDR_PD:       r_pd      <= w_wdata;
                    ADDR_DO:       r_do      <= w_wdata;
                    ADDR_DO_SET:   r_do      <= r_do | w_wdata;
                    ADDR_DO_CLR:   r_do      <= r_do & ~w_wdata;
                    ADDR_DO_TGL:   r_do      <= r_do ^ w_wdata;
                    ADDR_IRQ_EN:   r_en      <= w_wdata;
                    ADDR_IRQ_TYPE: r_type    <= w_wdata;
                    ADDR_IRQ_POL:  r_pol     <= w_wdata;
                    ADDR_IRQ_BOTH: r_both    <= w_wdata;
                    ADDR_FLT_EN:   r_flt_en  <= w_wdata;
                    ADDR_FLT_CNT:  r_flt_cnt <= apb.pwdata[3:0];
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the counter array is ordinary flops, not RAM, so each entry is reset explicitly.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_flt   <= '0;
            r_prev  <= '0;
            for (int i = 0; i < GPIO_NUM; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_pin;
            r_sync2 <= r_sync1;
            r_prev  <= w_flt;
            for (int i = 0; i < GPIO_NUM; i++) begin
                if (!r_flt_en[i]) begin
                    r_cnt[i] <= '0;
                    r_flt[i] <= r_sync2[i];
                end else if (w_cfg_chg || r_sync2[i] == r_flt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == r_flt_cnt) begin
                    r_cnt[i] <= '0;
                    r_flt[i] <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    // NOTE: default first in every always_comb so no path leaves a variable unassigned (no latch).
    always_comb begin
        w_rdata = '0;
        case (w_addr)
            ADDR_ID:       w_rdata[7:0]          = ID;
            ADDR_OE:       w_rdata[GPIO_NUM-1:0] = r_oe;
            ADDR_CS:       w_rdata[GPIO_NUM-1:0] = r_cs;
            ADDR_PU:       w_rdata[GPIO_NUM-1:0] = r_pu;
            ADDR_PD:       w_rdata[GPIO_NUM-1:0] = r_pd;
            ADDR_DO:       w_rdata[GPIO_NUM-1:0] = r_do;
            ADDR_DI:       w_rdata[GPIO_NUM-1:0] = w_flt;
            ADDR_IRQ_EN:   w_rdata[GPIO_NUM-1:0] = r_en;
            ADDR_IRQ_TYPE: w_rdata[GPIO_NUM-1:0] = r_type;
            ADDR_IRQ_POL:  w_rdata[GPIO_NUM-1:0] = r_pol;
            ADDR_IRQ_BOTH: w_rdata[GPIO_NUM-1:0] = r_both;
            ADDR_IRQ_STAT: w_rdata[GPIO_NUM-1:0] = r_stat;
            ADDR_FLT_EN:   w_rdata[GPIO_NUM-1:0] = r_flt_en;
            ADDR_FLT_CNT:  w_rdata[3:0]          = r_flt_cnt;
            default: ;
        endcase
    end

    always_comb begin
        gpio.gpio_oe                 = '0;
        gpio.gpio_cs                 = '0;
        gpio.gpio_pu                 = '0;
        gpio.gpio_pd                 = '0;
        gpio.gpio_out                = '0;
        gpio.gpio_oe[GPIO_NUM-1:0]   = r_oe;
        gpio.gpio_cs[GPIO_NUM-1:0]   = r_cs;
        gpio.gpio_pu[GPIO_NUM-1:0]   = r_pu;
        gpio.gpio_pd[GPIO_NUM-1:0]   = r_pd;
        gpio.gpio_out[GPIO_NUM-1:0]  = r_do;
    end

    assign apb.prdata  = w_rd ? w_rdata : '0;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = 1'b0;
    assign irq_o       = |(r_stat & r_en);

endmodule

// File: tb/tb_user_gpio_irq.sv
// Randomised and directed bench for user_gpio_irq against a cycle-level behavioural model.
module tb_user_gpio_irq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic irq, irq8;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    apb4_if     apb ();
    apb4_if     apb8 ();
    nmi_gpio_if gpio ();
    nmi_gpio_if gpio8 ();

    user_gpio_irq #(.ID(8'd255), .GPIO_NUM(32)) dut (
        .clk_i(clk), .rst_i(rst), .gpio(gpio), .apb(apb), .irq_o(irq)
    );

    user_gpio_irq #(.ID(8'd255), .GPIO_NUM(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .gpio(gpio8), .apb(apb8), .irq_o(irq8)
    );

    // Reference model of the 32-pin build. The filter is modelled as "the last FLT_CNT+1
    // synchronised samples all disagree with the filtered value" over a sample history.
    logic [31:0] m_oe, m_cs, m_pu, m_pd, m_do, m_en, m_type, m_pol, m_both, m_stat, m_flten;
    logic [31:0] m_s1, m_s2, m_fltreg, m_prev;
    logic [3:0]  m_fltcnt;
    logic [15:0] m_hist [32];
    logic [31:0] mt_f, mt_ev, mt_w1c;
    logic        mt_wr, mt_rise, mt_fall, mt_ok;

    function automatic logic [31:0] m_flt_now();
        return (m_flten & m_fltreg) | (~m_flten & m_s2);
    endfunction

    function automatic logic m_irq();
        return |(m_stat & m_en);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            8'h00: return 32'h0000_00FF;
            8'h04: return m_oe;
            8'h08: return m_cs;
            8'h0C: return m_pu;
            8'h10: return m_pd;
            8'h14: return m_do;
            8'h18: return m_flt_now();
            8'h28: return m_en;
            8'h2C: return m_type;
            8'h30: return m_pol;
            8'h34: return m_both;
            8'h38: return m_stat;
            8'h3C: return m_flten;
            8'h40: return {28'd0, m_fltcnt};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_oe, m_cs, m_pu, m_pd, m_do} = '0;
            {m_en, m_type, m_pol, m_both, m_stat, m_flten} = '0;
            {m_s1, m_s2, m_fltreg, m_prev} = '0;
            m_fltcnt = '0;
            for (int i = 0; i < 32; i++) m_hist[i] = '0;
        end else begin
            mt_f  = m_flt_now();
            mt_ev = '0;
            for (int i = 0; i < 32; i++) begin
                mt_rise = mt_f[i] && !m_prev[i];
                mt_fall = !mt_f[i] && m_prev[i];
                if (m_en[i]) begin
                    if (m_type[i]) mt_ev[i] = m_both[i] ? (mt_rise || mt_fall) : (m_pol[i] ? mt_rise : mt_fall);
                    else           mt_ev[i] = m_pol[i] ? mt_f[i] : !mt_f[i];
                end
            end
            mt_wr  = apb.psel && apb.penable && apb.pwrite;
            mt_w1c = (mt_wr && apb.paddr[7:0] == 8'h38) ? apb.pwdata : 32'd0;
            m_stat = (m_stat & ~mt_w1c) | mt_ev;
            m_prev = mt_f;
            for (int i = 0; i < 32; i++) begin
                m_hist[i] = {m_hist[i][14:0], m_s2[i]};
                if (!m_flten[i]) begin
                    m_fltreg[i] = m_s2[i];
                end else begin
                    mt_ok = 1'b1;
                    for (int j = 0; j <= int'(m_fltcnt); j++)
                        if (m_hist[i][j] == m_fltreg[i]) mt_ok = 1'b0;
                    if (mt_ok) m_fltreg[i] = m_s2[i];
                end
            end
            m_s2 = m_s1;
            m_s1 = gpio.gpio_in;
            if (mt_wr) begin
                case (apb.paddr[7:0])
                    8'h04: m_oe     = apb.pwdata;
                    8'h08: m_cs     = apb.pwdata;
                    8'h0C: m_pu     = apb.pwdata;
                    8'h10: m_pd     = apb.pwdata;
                    8'h14: m_do     = apb.pwdata;
                    8'h1C: m_do     = m_do | apb.pwdata;
                    8'h20: m_do     = m_do & ~apb.pwdata;
                    8'h24: m_do     = m_do ^ apb.pwdata;
                    8'h28: m_en     = apb.pwdata;
                    8'h2C: m_type   = apb.pwdata;
                    8'h30: m_pol    = apb.pwdata;
                    8'h34: m_both   = apb.pwdata;
                    8'h3C: m_flten  = apb.pwdata;
                    8'h40: m_fltcnt = apb.pwdata[3:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic bus_idle();
        apb.psel  = 1'b0; apb.penable  = 1'b0; apb.pwrite  = 1'b0;
        apb.paddr = '0;   apb.pwdata   = '0;   apb.pstrb   = 4'hF; apb.pprot  = '0;
        apb8.psel = 1'b0; apb8.penable = 1'b0; apb8.pwrite = 1'b0;
        apb8.paddr = '0;  apb8.pwdata  = '0;   apb8.pstrb  = 4'hF; apb8.pprot = '0;
    endtask

    task automatic bus_write(input bit narrow, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        if (narrow) begin apb8.psel = 1'b1; apb8.pwrite = 1'b1; apb8.paddr = {24'd0, a}; apb8.pwdata = d; end
        else        begin apb.psel  = 1'b1; apb.pwrite  = 1'b1; apb.paddr  = {24'd0, a}; apb.pwdata  = d; end
        @(negedge clk);
        if (narrow) apb8.penable = 1'b1; else apb.penable = 1'b1;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_read(input bit narrow, input logic [7:0] a,
                            output logic [31:0] got, output logic [31:0] exp);
        @(negedge clk);
        if (narrow) begin apb8.psel = 1'b1; apb8.pwrite = 1'b0; apb8.paddr = {24'd0, a}; end
        else        begin apb.psel  = 1'b1; apb.pwrite  = 1'b0; apb.paddr  = {24'd0, a}; end
        @(negedge clk);
        if (narrow) apb8.penable = 1'b1; else apb.penable = 1'b1;
        #1;
        got = narrow ? apb8.prdata : apb.prdata;
        exp = m_read(a);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus_write(1'b0, a, d);
    endtask

    task automatic test_reset();
        logic [31:0] got, exp;
        wr(8'h04, 32'hFFFF_FFFF);
        wr(8'h08, 32'h0000_00A5);
        wr(8'h14, 32'h0000_0055);
        wr(8'h28, 32'h0000_0001);
        @(negedge clk);
        checks++;
        if ({gpio.gpio_oe, irq} !== {32'hFFFF_FFFF, 1'b1}) begin
            errors++; $display("FAIL pre_reset oe=%h irq=%b need oe=ffffffff irq=1", gpio.gpio_oe, irq);
        end
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.paddr = 32'h14; apb.pwdata = 32'h1234;
        @(negedge clk);
        apb.penable = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({gpio.gpio_oe, gpio.gpio_cs, gpio.gpio_pu, gpio.gpio_pd, gpio.gpio_out, irq} !== '0) begin
            errors++; $display("FAIL async_reset oe=%h cs=%h out=%h irq=%b need all 0",
                               gpio.gpio_oe, gpio.gpio_cs, gpio.gpio_out, irq);
        end
        @(negedge clk);
        bus_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus_read(1'b0, 8'h00, got, exp);
        checks++;
        if (got !== 32'h0000_00FF) begin errors++; $display("FAIL id_read got=%h need=000000ff", got); end
        bus_read(1'b0, 8'h44, got, exp);
        checks++;
        if (got !== 32'd0) begin errors++; $display("FAIL unmapped_read got=%h need=00000000", got); end
        bus_read(1'b0, 8'h14, got, exp);
        checks++;
        if (got !== 32'd0) begin errors++; $display("FAIL discarded_write DO got=%h need=00000000", got); end
        checks++;
        if ({apb.pready, apb.pslverr} !== 2'b10) begin
            errors++; $display("FAIL apb_ties pready=%b pslverr=%b need 1/0", apb.pready, apb.pslverr);
        end
    endtask

    task automatic test_atomic_do();
        logic [31:0] got, exp;
        logic [7:0]  ops  [4] = '{8'h14, 8'h1C, 8'h20, 8'h24};
        logic [31:0] data [4] = '{32'h00F0, 32'h000F, 32'h0081, 32'hFFFF};
        logic [31:0] want [4] = '{32'h00F0, 32'h00FF, 32'h007E, 32'hFF81};
        for (int k = 0; k < 4; k++) begin
            wr(ops[k], data[k]);
            checks++;
            if (gpio.gpio_out !== want[k]) begin
                errors++; $display("FAIL do_op%0d gpio_out=%h need=%h", k, gpio.gpio_out, want[k]);
            end
        end
        bus_read(1'b0, 8'h1C, got, exp);
        checks++;
        if (got !== 32'd0) begin errors++; $display("FAIL wo_read DO_SET got=%h need=00000000", got); end
    endtask

    task automatic test_rise_irq();
        logic [31:0] got, exp;
        wr(8'h28, 32'h0);
        wr(8'h2C, 32'h8);
        wr(8'h30, 32'h8);
        wr(8'h38, 32'hFFFF_FFFF);
        wr(8'h28, 32'h8);
        gpio.gpio_in[3] = 1'b1;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            checks++;
            if (irq !== (e == 2)) begin errors++; $display("FAIL rise_latency edge%0d irq=%b need=%b", e, irq, e == 2); end
        end
        bus_read(1'b0, 8'h38, got, exp);
        checks++;
        if (got !== 32'h8) begin errors++; $display("FAIL rise_stat got=%h need=00000008", got); end
        wr(8'h38, 32'h8);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rise_w1c irq=%b need=0", irq); end
        gpio.gpio_in[3] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rise_ignores_fall irq=%b need=0", irq); end
    endtask

    task automatic test_level_low();
        logic [31:0] got, exp;
        wr(8'h28, 32'h0);
        wr(8'h2C, 32'h0);
        wr(8'h30, 32'h0);
        wr(8'h38, 32'hFFFF_FFFF);
        wr(8'h28, 32'h20);
        wr(8'h38, 32'h20);
        bus_read(1'b0, 8'h38, got, exp);
        checks++;
        if (got !== 32'h20 || irq !== 1'b1) begin
            errors++; $display("FAIL level_set_wins stat=%h irq=%b need stat=00000020 irq=1", got, irq);
        end
        gpio.gpio_in[5] = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL level_sticky irq=%b need=1", irq); end
        wr(8'h38, 32'h20);
        bus_read(1'b0, 8'h38, got, exp);
        checks++;
        if (got !== 32'h0 || irq !== 1'b0) begin
            errors++; $display("FAIL level_cleared stat=%h irq=%b need stat=0 irq=0", got, irq);
        end
        gpio.gpio_in[5] = 1'b0;
        wr(8'h28, 32'h0);
    endtask

    task automatic hold_di_read();
        @(negedge clk);
        apb.psel = 1'b1; apb.pwrite = 1'b0; apb.paddr = 32'h18; apb.penable = 1'b1;
    endtask

    task automatic test_glitch_filter();
        wr(8'h2C, 32'h1);
        wr(8'h30, 32'h1);
        wr(8'h34, 32'h0);
        wr(8'h3C, 32'h1);
        wr(8'h40, 32'h3);
        repeat (4) @(negedge clk);
        wr(8'h38, 32'hFFFF_FFFF);
        wr(8'h28, 32'h1);
        hold_di_read();
        gpio.gpio_in[0] = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            checks++;
            if (apb.prdata[0] !== 1'b0 || irq !== 1'b0) begin
                errors++; $display("FAIL glitch3 edge%0d di0=%b irq=%b need 0/0", e, apb.prdata[0], irq);
            end
            if (e == 2) begin @(negedge clk); gpio.gpio_in[0] = 1'b0; end
        end
        repeat (4) @(negedge clk);
        gpio.gpio_in[0] = 1'b1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            checks++;
            if (apb.prdata[0] !== (e >= 5 && e <= 8) || irq !== (e >= 6)) begin
                errors++; $display("FAIL glitch4 edge%0d di0=%b irq=%b need %b/%b",
                                   e, apb.prdata[0], irq, e >= 5 && e <= 8, e >= 6);
            end
            checks++;
            if (apb.prdata !== m_read(8'h18)) begin
                errors++; $display("FAIL glitch4_model edge%0d di=%h need=%h", e, apb.prdata, m_read(8'h18));
            end
            if (e == 3) begin @(negedge clk); gpio.gpio_in[0] = 1'b0; end
        end
        @(negedge clk);
        bus_idle();
        wr(8'h28, 32'h0);
        wr(8'h3C, 32'h0);
        wr(8'h38, 32'hFFFF_FFFF);
    endtask

    task automatic test_both_edges();
        logic [31:0] got, exp;
        wr(8'h2C, 32'h8000_0000);
        wr(8'h34, 32'h8000_0000);
        wr(8'h30, 32'h0);
        wr(8'h38, 32'hFFFF_FFFF);
        wr(8'h28, 32'h8000_0000);
        for (int k = 0; k < 2; k++) begin
            gpio.gpio_in[31] = (k == 0);
            repeat (4) @(negedge clk);
            bus_read(1'b0, 8'h38, got, exp);
            checks++;
            if (got !== 32'h8000_0000 || irq !== 1'b1) begin
                errors++; $display("FAIL both_edge%0d stat=%h irq=%b need stat=80000000 irq=1", k, got, irq);
            end
            wr(8'h38, 32'h8000_0000);
            checks++;
            if (irq !== 1'b0) begin errors++; $display("FAIL both_w1c%0d irq=%b need=0", k, irq); end
        end
        wr(8'h28, 32'h0);
    endtask

    task automatic test_narrow_build();
        logic [31:0] got, exp;
        bus_write(1'b1, 8'h04, 32'hFFFF_FFFF);
        checks++;
        if (gpio8.gpio_oe !== 32'h0000_00FF) begin
            errors++; $display("FAIL narrow_pad_oe got=%h need=000000ff", gpio8.gpio_oe);
        end
        bus_read(1'b1, 8'h04, got, exp);
        checks++;
        if (got !== 32'h0000_00FF) begin errors++; $display("FAIL narrow_oe_read got=%h need=000000ff", got); end
        bus_write(1'b1, 8'h34, 32'hA5A5_A5A5);
        bus_read(1'b1, 8'h34, got, exp);
        checks++;
        if (got !== 32'h0000_00A5) begin errors++; $display("FAIL narrow_both_read got=%h need=000000a5", got); end
    endtask

    task automatic test_random_do();
        logic [31:0] got, exp;
        logic [7:0]  ops [4] = '{8'h14, 8'h1C, 8'h20, 8'h24};
        for (int k = 0; k < 30; k++) begin
            wr(ops[$urandom_range(3)], $urandom);
            bus_read(1'b0, 8'h14, got, exp);
            checks++;
            if (got !== exp || gpio.gpio_out !== exp) begin
                errors++; $display("FAIL rand_do%0d read=%h pad=%h need=%h", k, got, gpio.gpio_out, exp);
            end
        end
    endtask

    task automatic test_random_irq(input bit use_filter);
        logic [31:0] got, exp;
        for (int round = 0; round < 3; round++) begin
            repeat (24) @(negedge clk);
            wr(8'h3C, use_filter ? $urandom : 32'h0);
            wr(8'h40, use_filter ? 32'($urandom_range(5)) : 32'h0);
            wr(8'h2C, use_filter ? 32'hFFFF_FFFF : $urandom);
            wr(8'h30, $urandom);
            wr(8'h34, $urandom);
            wr(8'h28, $urandom);
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                checks++;
                if (irq !== m_irq()) begin errors++; $display("FAIL rand_irq r%0d c%0d irq=%b need=%b", round, c, irq, m_irq()); end
                if ($urandom_range(2) == 0)
                    gpio.gpio_in[$urandom_range(use_filter ? 7 : 31)] ^= 1'b1;
                case ($urandom_range(15))
                    0: wr(8'h38, $urandom);
                    1: wr(8'h28, $urandom);
                    2, 3: begin
                        bus_read(1'b0, ($urandom_range(1) == 0) ? 8'h38 : 8'h18, got, exp);
                        checks++;
                        if (got !== exp) begin errors++; $display("FAIL rand_read r%0d c%0d got=%h need=%h", round, c, got, exp); end
                    end
                    default: ;
                endcase
            end
        end
        repeat (24) @(negedge clk);
        wr(8'h28, 32'h0);
        wr(8'h3C, 32'h0);
        wr(8'h38, 32'hFFFF_FFFF);
    endtask

    initial begin
        bus_idle();
        gpio.gpio_in  = '0;
        gpio8.gpio_in = '0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_atomic_do();
        test_rise_irq();
        test_level_low();
        test_glitch_filter();
        test_both_edges();
        test_narrow_build();
        test_random_do();
        test_random_irq(1'b0);
        test_random_irq(1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
